// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle main controller for the RV32 subset (R-type, lw, sw, beq)
// Ports: CLK, Reset (async, active-low), Opcode (IR[6:0]), MemReady (memory handshake);
//        datapath controls IRWrite, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
//        MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp; Fault (01 illegal opcode, 10 memory
//        timeout) and State (debug view of the current state).
module multicycle_control_fsm #(
    parameter logic [6:0]  OPC_R       = 7'd51,
    parameter logic [6:0]  OPC_LW      = 7'd3,
    parameter logic [6:0]  OPC_SW      = 7'd35,
    parameter logic [6:0]  OPC_BEQ     = 7'd99,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [6:0] Opcode,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] Fault,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        ADDR   = 4'd2,
        MEMRD  = 4'd3,
        LWB    = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        HALT   = 4'd9
    } stateT;

    stateT      curState, nextState;
    logic [1:0] nextFault;
    logic [7:0] waitCnt;
    logic       memState, timedOut;

    assign State    = curState;
    assign memState = curState == FETCH || curState == MEMRD || curState == MEMWR;
    // A ready on the very cycle the count hits the limit still wins over the timeout.
    assign timedOut = MEM_TIMEOUT != 0 && memState && !MemReady && waitCnt == 8'(MEM_TIMEOUT);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            curState <= FETCH;
            Fault    <= 2'b00;
            waitCnt  <= '0;
        end else begin
            curState <= nextState;
            Fault    <= nextFault;
            // Any state change clears the count, which covers entry to every memory state.
            waitCnt  <= nextState != curState ? '0 : (memState && !MemReady) ? waitCnt + 8'd1 : waitCnt;
        end
    end

    always_comb begin
        nextState   = curState;
        nextFault   = Fault;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        case (curState)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                nextState = MemReady ? DECODE : timedOut ? HALT : FETCH;
            end
            DECODE: begin
                ALUSrcB   = 2'b11;
                nextState = (Opcode == OPC_LW || Opcode == OPC_SW) ? ADDR :
                            Opcode == OPC_R   ? EXEC :
                            Opcode == OPC_BEQ ? BRANCH : HALT;
                nextFault = nextState == HALT ? 2'b01 : Fault;
            end
            ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = Opcode == OPC_LW ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nextState = MemReady ? LWB : timedOut ? HALT : MEMRD;
            end
            LWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                nextState = FETCH;
            end
            MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                nextState = MemReady ? FETCH : timedOut ? HALT : MEMWR;
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nextState = RWB;
            end
            RWB: begin
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                nextState   = FETCH;
            end
            HALT:    nextState = HALT;
            default: nextState = FETCH;
        endcase
        if (timedOut) nextFault = 2'b10;
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven and randomized checks of the multi-cycle controller
module tb_multicycle_control_fsm;
    localparam logic [6:0] OPC_R   = 7'd51;
    localparam logic [6:0] OPC_LW  = 7'd3;
    localparam logic [6:0] OPC_SW  = 7'd35;
    localparam logic [6:0] OPC_BEQ = 7'd99;
    localparam int         TMO     = 16;

    typedef struct packed {
        logic       irw, pcw, pcwc, pcs, iord, mrd, mwr, m2r, rw, asa;
        logic [1:0] asb, aop;
    } outT;

    typedef struct {
        logic [6:0]      op;
        int              n;
        logic [4:0][3:0] seq;
    } vecT;

    logic       CLK = 1'b0;
    logic       Reset, MemReady;
    logic [6:0] Opcode;
    logic       IRWrite, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, Fault;
    logic [3:0] State;
    outT        actOut;
    logic [1:0] modelFault = 2'b00;
    int         errors = 0;
    int         checks = 0;

    multicycle_control_fsm dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .Fault(Fault), .State(State)
    );

    always #5 CLK = ~CLK;

    assign actOut = {IRWrite, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
                     MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp};

    // Per-state control values straight from the state descriptions.
    function automatic outT expOut(input logic [3:0] st, input logic mr);
        outT o = '0;
        case (st)
            4'd0: begin o.mrd = 1'b1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
            4'd1: o.asb = 2'b11;
            4'd2: begin o.asa = 1'b1; o.asb = 2'b10; end
            4'd3: begin o.mrd = 1'b1; o.iord = 1'b1; end
            4'd4: begin o.rw = 1'b1; o.m2r = 1'b1; end
            4'd5: begin o.mwr = 1'b1; o.iord = 1'b1; end
            4'd6: begin o.asa = 1'b1; o.aop = 2'b10; end
            4'd7: o.rw = 1'b1;
            4'd8: begin o.asa = 1'b1; o.aop = 2'b01; o.pcwc = 1'b1; o.pcs = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive MemReady just after the edge, check mid-cycle, return after next edge.
    task automatic cyc(input logic mr, input logic [3:0] st, input string nm);
        MemReady = mr;
        @(negedge CLK);
        chk({nm, " state"}, {12'b0, State}, {12'b0, st});
        chk({nm, " outputs"}, {2'b0, actOut}, {2'b0, expOut(st, mr)});
        chk({nm, " fault"}, {14'b0, Fault}, {14'b0, modelFault});
        @(posedge CLK);
        #1;
    endtask

    // A memory wait: forced-low cycles first, then random readiness; the limit-th low cycle times out.
    task automatic memPhase(input logic [3:0] st, input int lows, input int pct, output bit ok);
        bit mr;
        bit done;
        ok = 0;
        done = 0;
        for (int n = 0; n <= TMO && !done; n++) begin
            mr = (n >= lows) && (int'($urandom_range(99)) < pct);
            cyc(mr, st, "mem");
            if (mr) begin
                ok = 1;
                done = 1;
            end else if (n == TMO) modelFault = 2'b10;
        end
    endtask

    task automatic runInstr(input logic [6:0] op, input int dLows, input int pct, output bit halted);
        bit ok;
        Opcode = op;
        halted = 0;
        memPhase(4'd0, 0, pct, ok);
        if (!ok) halted = 1;
        else begin
            cyc(rb(), 4'd1, "decode");
            if (op == OPC_LW || op == OPC_SW) begin
                cyc(rb(), 4'd2, "addr");
                memPhase(op == OPC_LW ? 4'd3 : 4'd5, dLows, pct, ok);
                if (!ok) halted = 1;
                else if (op == OPC_LW) cyc(rb(), 4'd4, "lwb");
            end else if (op == OPC_R) begin
                cyc(rb(), 4'd6, "exec");
                cyc(rb(), 4'd7, "rwb");
            end else if (op == OPC_BEQ) cyc(rb(), 4'd8, "branch");
            else begin
                modelFault = 2'b01;
                halted = 1;
            end
        end
    endtask

    task automatic haltFor(input int n);
        for (int i = 0; i < n; i++) cyc(rb(), 4'd9, "halt");
    endtask

    task automatic resetPulse();
        Reset = 1'b0;
        #1;
        modelFault = 2'b00;
        chk("reset state", {12'b0, State}, 16'd0);
        chk("reset fault", {14'b0, Fault}, 16'd0);
        chk("reset outputs", {2'b0, actOut}, {2'b0, expOut(4'd0, MemReady)});
        @(posedge CLK);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecT vecs[4];
        bit  h;
        int  r;
        logic [6:0] op;
        vecs[0] = '{op: OPC_R,   n: 4, seq: {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        vecs[1] = '{op: OPC_LW,  n: 5, seq: {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        vecs[2] = '{op: OPC_SW,  n: 4, seq: {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        vecs[3] = '{op: OPC_BEQ, n: 3, seq: {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};

        Reset = 1'b0;
        MemReady = 1'b0;
        Opcode = 7'd0;
        #2;
        chk("por state", {12'b0, State}, 16'd0);
        chk("por fault", {14'b0, Fault}, 16'd0);
        chk("por outputs", {2'b0, actOut}, {2'b0, expOut(4'd0, 1'b0)});
        @(posedge CLK);
        #1;
        Reset = 1'b1;

        // Fixed traces with MemReady tied high.
        for (int v = 0; v < 4; v++) begin
            Opcode = vecs[v].op;
            for (int i = 0; i < vecs[v].n; i++) cyc(1'b1, vecs[v].seq[i], "vec");
        end

        // Illegal opcode: halt, fault held, reset recovers.
        runInstr(7'h7F, 0, 100, h);
        haltFor(22);
        resetPulse();

        // Five low cycles in MEMRD, then completion.
        runInstr(OPC_LW, 5, 100, h);
        // Ready arrives exactly when the count reaches the limit: no fault.
        runInstr(OPC_LW, TMO, 100, h);
        runInstr(OPC_SW, TMO, 100, h);
        // MEMRD never ready: timeout.
        runInstr(OPC_LW, 100, 100, h);
        haltFor(5);
        resetPulse();
        // FETCH never ready: timeout.
        runInstr(OPC_R, 0, 0, h);
        haltFor(5);
        resetPulse();

        // Asynchronous reset in the middle of MEMWR.
        Opcode = OPC_SW;
        cyc(1'b1, 4'd0, "sw fetch");
        cyc(1'b1, 4'd1, "sw decode");
        cyc(1'b1, 4'd2, "sw addr");
        MemReady = 1'b0;
        @(negedge CLK);
        chk("memwr MemWrite before reset", {15'b0, MemWrite}, 16'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("memwr MemWrite after reset", {15'b0, MemWrite}, 16'd0);
        chk("memwr state after reset", {12'b0, State}, 16'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        runInstr(OPC_R, 0, 100, h);

        // Random instruction mix with random memory readiness.
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(9));
            op = r < 2 ? OPC_R : r < 4 ? OPC_LW : r < 6 ? OPC_SW : r < 9 ? OPC_BEQ : 7'h13;
            runInstr(op, int'($urandom_range(3)), 70, h);
            if (h) begin
                haltFor(3);
                resetPulse();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
